ex_stage: RTL and testbench



---
 rtl/ex_stage_pkg.sv | 65 ++++++
 rtl/div_unit.sv | 76 +++++++
 rtl/ex_stage.sv | 129 ++++++++++++
 tb/tb_ex_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared codes and types for the execute stage: unit selects, operation codes,
// memory op codes and the divider state encoding.
package ex_stage_pkg;

    localparam int WORD_BUS      = 32;
    localparam int REG_ADDR_BUS  = 5;
    localparam int ALU_SEL_BUS   = 3;
    localparam int EX_OP_LOW_BUS = 5;
    localparam int MEM_OP_BUS    = 4;

    localparam logic [2:0] ALU_NOP    = 3'd0;
    localparam logic [2:0] ALU_LOGIC  = 3'd1;
    localparam logic [2:0] ALU_SHIFT  = 3'd2;
    localparam logic [2:0] ALU_ARITH  = 3'd3;
    localparam logic [2:0] ALU_MOVE   = 3'd4;
    localparam logic [2:0] ALU_MULDIV = 3'd5;
    localparam logic [2:0] ALU_MEM    = 3'd6;

    localparam logic [4:0] EX_AND   = 5'd0;
    localparam logic [4:0] EX_OR    = 5'd1;
    localparam logic [4:0] EX_XOR   = 5'd2;
    localparam logic [4:0] EX_NOR   = 5'd3;
    localparam logic [4:0] EX_LUI   = 5'd4;
    localparam logic [4:0] EX_SLL   = 5'd5;
    localparam logic [4:0] EX_SRL   = 5'd6;
    localparam logic [4:0] EX_SRA   = 5'd7;
    localparam logic [4:0] EX_ADD   = 5'd8;
    localparam logic [4:0] EX_ADDU  = 5'd9;
    localparam logic [4:0] EX_SUB   = 5'd10;
    localparam logic [4:0] EX_SUBU  = 5'd11;
    localparam logic [4:0] EX_SLT   = 5'd12;
    localparam logic [4:0] EX_SLTU  = 5'd13;
    localparam logic [4:0] EX_MFHI  = 5'd14;
    localparam logic [4:0] EX_MFLO  = 5'd15;
    localparam logic [4:0] EX_MTHI  = 5'd16;
    localparam logic [4:0] EX_MTLO  = 5'd17;
    localparam logic [4:0] EX_MULT  = 5'd18;
    localparam logic [4:0] EX_MULTU = 5'd19;
    localparam logic [4:0] EX_DIV   = 5'd20;
    localparam logic [4:0] EX_DIVU  = 5'd21;

    localparam logic [3:0] MEM_OP_NOP = 4'd0;
    localparam logic [3:0] MEM_OP_LB  = 4'd1;
    localparam logic [3:0] MEM_OP_LBU = 4'd2;
    localparam logic [3:0] MEM_OP_LH  = 4'd3;
    localparam logic [3:0] MEM_OP_LHU = 4'd4;
    localparam logic [3:0] MEM_OP_LW  = 4'd5;
    localparam logic [3:0] MEM_OP_SB  = 4'd6;
    localparam logic [3:0] MEM_OP_SH  = 4'd7;
    localparam logic [3:0] MEM_OP_SW  = 4'd8;

    localparam logic [31:0] ZERO_WORD = 32'd0;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    // Signed overflow of a + b = s: like-signed operands giving an unlike-signed sum.
    function automatic logic add_overflow(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

endpackage

// File: rtl/div_unit.sv
// 32-step restoring divider on operand magnitudes with sign fix-up; done is
// high during the final step and quotient/remainder are valid in that cycle.
module div_unit import ex_stage_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    logic [4:0]  count;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        q_neg, r_neg;

    logic        a_neg, b_neg, fits;
    logic [32:0] shifted, trial;
    logic [31:0] rem_n, quo_n;

    assign a_neg = is_signed && dividend[31];
    assign b_neg = is_signed && divisor[31];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign fits    = !trial[32];
    assign rem_n   = fits ? trial[31:0] : shifted[31:0];
    assign quo_n   = {quo_q[30:0], fits};

    assign busy      = (state == DIV_BUSY);
    assign done      = busy && (count == 5'd31);
    assign quotient  = q_neg ? (ZERO_WORD - quo_n) : quo_n;
    assign remainder = r_neg ? (ZERO_WORD - rem_n) : rem_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            count <= 5'd0;
            rem_q <= ZERO_WORD;
            quo_q <= ZERO_WORD;
            dvs_q <= ZERO_WORD;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        count <= 5'd0;
                        rem_q <= ZERO_WORD;
                        quo_q <= a_neg ? (ZERO_WORD - dividend) : dividend;
                        dvs_q <= b_neg ? (ZERO_WORD - divisor) : divisor;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                    end
                end
                default: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    if (count == 5'd31) begin
                        state <= DIV_IDLE;
                        count <= 5'd0;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO, multiply and iterative divide, registered into EX/MEM.
// Stall is requested while a divide is being accepted or iterated.
module ex_stage import ex_stage_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ex_alusel,
    input  logic [4:0]  ex_aluop,
    input  logic [31:0] ex_srcLeft,
    input  logic [31:0] ex_srcRight,
    input  logic [31:0] ex_offset,
    input  logic [3:0]  ex_memop,
    input  logic [4:0]  ex_dest,
    input  logic        ex_writeEnable,
    output logic [31:0] mem_result,
    output logic [31:0] mem_storeData,
    output logic [3:0]  mem_memop,
    output logic [4:0]  mem_dest,
    output logic        mem_writeEnable,
    output logic        stall_req
);

    logic [31:0] hi, lo, hi_n, lo_n, res;
    logic [31:0] sum, diff, div_quo, div_rem;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        op_ok, kill_we, is_div, div_start, div_busy, div_done;

    assign sum    = ex_srcLeft + ex_srcRight;
    assign diff   = ex_srcLeft - ex_srcRight;
    assign prod_s = $signed({{32{ex_srcLeft[31]}}, ex_srcLeft}) *
                    $signed({{32{ex_srcRight[31]}}, ex_srcRight});
    assign prod_u = {32'd0, ex_srcLeft} * {32'd0, ex_srcRight};

    assign is_div    = (ex_alusel == ALU_MULDIV) && (ex_aluop == EX_DIV || ex_aluop == EX_DIVU);
    assign div_start = is_div && (ex_srcRight != ZERO_WORD) && !div_busy;
    assign stall_req = div_start || (div_busy && !div_done);

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (ex_aluop == EX_DIV),
        .dividend  (ex_srcLeft),
        .divisor   (ex_srcRight),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        res     = ZERO_WORD;
        op_ok   = ENABLE;
        kill_we = DISABLE;
        hi_n    = hi;
        lo_n    = lo;
        case (ex_alusel)
            ALU_LOGIC: case (ex_aluop)
                EX_AND:  res = ex_srcLeft & ex_srcRight;
                EX_OR:   res = ex_srcLeft | ex_srcRight;
                EX_XOR:  res = ex_srcLeft ^ ex_srcRight;
                EX_NOR:  res = ~(ex_srcLeft | ex_srcRight);
                EX_LUI:  res = {ex_srcRight[15:0], 16'd0};
                default: op_ok = DISABLE;
            endcase
            ALU_SHIFT: case (ex_aluop)
                EX_SLL:  res = ex_srcRight << ex_srcLeft[4:0];
                EX_SRL:  res = ex_srcRight >> ex_srcLeft[4:0];
                EX_SRA:  res = $signed(ex_srcRight) >>> ex_srcLeft[4:0];
                default: op_ok = DISABLE;
            endcase
            ALU_ARITH: case (ex_aluop)
                EX_ADD:  begin res = sum;  kill_we = add_overflow(ex_srcLeft, ex_srcRight, sum); end
                EX_ADDU: res = sum;
                EX_SUB:  begin res = diff; kill_we = add_overflow(ex_srcLeft, ~ex_srcRight, diff); end
                EX_SUBU: res = diff;
                EX_SLT:  res = {31'd0, $signed(ex_srcLeft) < $signed(ex_srcRight)};
                EX_SLTU: res = {31'd0, ex_srcLeft < ex_srcRight};
                default: op_ok = DISABLE;
            endcase
            ALU_MOVE: case (ex_aluop)
                EX_MFHI: res = hi;
                EX_MFLO: res = lo;
                EX_MTHI: begin hi_n = ex_srcLeft; kill_we = ENABLE; end
                EX_MTLO: begin lo_n = ex_srcLeft; kill_we = ENABLE; end
                default: op_ok = DISABLE;
            endcase
            ALU_MULDIV: case (ex_aluop)
                EX_MULT:  {hi_n, lo_n} = prod_s;
                EX_MULTU: {hi_n, lo_n} = prod_u;
                EX_DIV, EX_DIVU: kill_we = ENABLE;
                default:  op_ok = DISABLE;
            endcase
            ALU_MEM: res = ex_srcLeft + ex_offset;
            default: op_ok = DISABLE;
        endcase
        if (div_done) begin
            hi_n = div_rem;
            lo_n = div_quo;
        end
        // While stalled the held instruction is only registered on the divide's final cycle.
        if (stall_req) begin
            op_ok = DISABLE;
            hi_n  = hi;
            lo_n  = lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi              <= ZERO_WORD;
            lo              <= ZERO_WORD;
            mem_result      <= ZERO_WORD;
            mem_storeData   <= ZERO_WORD;
            mem_memop       <= MEM_OP_NOP;
            mem_dest        <= REG_ZERO;
            mem_writeEnable <= DISABLE;
        end else begin
            hi              <= hi_n;
            lo              <= lo_n;
            mem_result      <= op_ok ? res : ZERO_WORD;
            mem_storeData   <= op_ok ? ex_srcRight : ZERO_WORD;
            mem_memop       <= op_ok ? ex_memop : MEM_OP_NOP;
            mem_dest        <= op_ok ? ex_dest : REG_ZERO;
            mem_writeEnable <= op_ok && ex_writeEnable && !kill_we;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Execute-stage bench: directed corner cases plus random instruction stream
// checked every cycle against an arithmetic model of the stage.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_aluop;
    logic [31:0] ex_srcLeft, ex_srcRight, ex_offset;
    logic [3:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic [31:0] mem_result, mem_storeData;
    logic [3:0]  mem_memop;
    logic [4:0]  mem_dest;
    logic        mem_writeEnable;
    logic        stall_req;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_alusel       (ex_alusel),
        .ex_aluop        (ex_aluop),
        .ex_srcLeft      (ex_srcLeft),
        .ex_srcRight     (ex_srcRight),
        .ex_offset       (ex_offset),
        .ex_memop        (ex_memop),
        .ex_dest         (ex_dest),
        .ex_writeEnable  (ex_writeEnable),
        .mem_result      (mem_result),
        .mem_storeData   (mem_storeData),
        .mem_memop       (mem_memop),
        .mem_dest        (mem_dest),
        .mem_writeEnable (mem_writeEnable),
        .stall_req       (stall_req)
    );

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: architectural HI/LO and the EX/MEM contents expected after the last edge.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] e_res = 32'd0, e_store = 32'd0;
    logic [3:0]  e_memop = 4'd0;
    logic [4:0]  e_dest = 5'd0;
    logic        e_we = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_bubble();
        e_res = 32'd0; e_store = 32'd0; e_memop = MEM_OP_NOP; e_dest = 5'd0; e_we = 1'b0;
    endtask

    task automatic check_outputs();
        chk("mem_result",      mem_result,      e_res);
        chk("mem_storeData",   mem_storeData,   e_store);
        chk("mem_memop",       mem_memop,       e_memop);
        chk("mem_dest",        mem_dest,        e_dest);
        chk("mem_writeEnable", mem_writeEnable, e_we);
        chk("hi",              dut.hi,          m_hi);
        chk("lo",              dut.lo,          m_lo);
    endtask

    task automatic drive(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] off, input logic [3:0] mop,
                         input logic [4:0] dst, input logic we);
        ex_alusel = sel; ex_aluop = op; ex_srcLeft = a; ex_srcRight = b;
        ex_offset = off; ex_memop = mop; ex_dest = dst; ex_writeEnable = we;
    endtask

    // Presents one instruction, acting as the front end (holds it while stalled),
    // and checks outputs and stall on every cycle it occupies EX.
    task automatic run_op(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] off, input logic [3:0] mop,
                          input logic [4:0] dst, input logic we, output int stalls);
        logic        valid, kill;
        logic [31:0] r, nhi, nlo;
        logic [63:0] pu;
        longint      sa, sb, s, q, rm;
        int          ncyc;
        valid = 1'b1; kill = 1'b0; r = 32'd0; nhi = m_hi; nlo = m_lo; ncyc = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (sel)
            ALU_LOGIC: case (op)
                EX_AND: r = a & b;
                EX_OR:  r = a | b;
                EX_XOR: r = a ^ b;
                EX_NOR: r = ~(a | b);
                EX_LUI: r = b << 16;
                default: valid = 1'b0;
            endcase
            ALU_SHIFT: case (op)
                EX_SLL: r = b << a[4:0];
                EX_SRL: r = b >> a[4:0];
                EX_SRA: begin s = sb >>> a[4:0]; r = s[31:0]; end
                default: valid = 1'b0;
            endcase
            ALU_ARITH: case (op)
                EX_ADD:  begin s = sa + sb; r = s[31:0]; kill = (s > MAXI) || (s < MINI); end
                EX_ADDU: r = a + b;
                EX_SUB:  begin s = sa - sb; r = s[31:0]; kill = (s > MAXI) || (s < MINI); end
                EX_SUBU: r = a - b;
                EX_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
                EX_SLTU: r = (a < b) ? 32'd1 : 32'd0;
                default: valid = 1'b0;
            endcase
            ALU_MOVE: case (op)
                EX_MFHI: r = m_hi;
                EX_MFLO: r = m_lo;
                EX_MTHI: begin nhi = a; kill = 1'b1; end
                EX_MTLO: begin nlo = a; kill = 1'b1; end
                default: valid = 1'b0;
            endcase
            ALU_MULDIV: case (op)
                EX_MULT:  begin s = sa * sb; nhi = s[63:32]; nlo = s[31:0]; end
                EX_MULTU: begin pu = {32'd0, a} * {32'd0, b}; nhi = pu[63:32]; nlo = pu[31:0]; end
                EX_DIV: begin
                    kill = 1'b1;
                    if (b != 32'd0) begin
                        ncyc = 33; q = sa / sb; rm = sa % sb; nlo = q[31:0]; nhi = rm[31:0];
                    end
                end
                EX_DIVU: begin
                    kill = 1'b1;
                    if (b != 32'd0) begin
                        ncyc = 33; nlo = a / b; nhi = a % b;
                    end
                end
                default: valid = 1'b0;
            endcase
            ALU_MEM: r = a + off;
            default: valid = 1'b0;
        endcase
        drive(sel, op, a, b, off, mop, dst, we);
        stalls = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check_outputs();
            chk("stall_req", stall_req, (c < ncyc - 1));
            if (stall_req) stalls++;
            @(posedge clk);
            #1;
            if (c < ncyc - 1) begin
                expect_bubble();
            end else begin
                m_hi = nhi; m_lo = nlo;
                if (valid) begin
                    e_res = r; e_store = b; e_memop = mop; e_dest = dst; e_we = we && !kill;
                end else begin
                    expect_bubble();
                end
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 15);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          st;
        logic [2:0]  sel;
        logic [4:0]  op;

        rst = 1'b1;
        drive(ALU_NOP, 5'd0, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_stall", stall_req, 1'b0);
        rst = 1'b0;

        run_op(ALU_ARITH, EX_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, MEM_OP_NOP, 5'd3, 1'b1, st);
        chk("add_ovf_we", mem_writeEnable, 1'b0);
        run_op(ALU_ARITH, EX_ADDU, 32'h7FFF_FFFF, 32'd1, 32'd0, MEM_OP_NOP, 5'd3, 1'b1, st);
        chk("addu_res", mem_result, 32'h8000_0000);
        chk("addu_we", mem_writeEnable, 1'b1);
        run_op(ALU_SHIFT, EX_SRA, 32'd4, 32'h8000_0000, 32'd0, MEM_OP_NOP, 5'd4, 1'b1, st);
        chk("sra_res", mem_result, 32'hF800_0000);
        run_op(ALU_ARITH, EX_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, MEM_OP_NOP, 5'd4, 1'b1, st);
        chk("slt_res", mem_result, 32'd1);
        run_op(ALU_ARITH, EX_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, MEM_OP_NOP, 5'd4, 1'b1, st);
        chk("sltu_res", mem_result, 32'd0);

        run_op(ALU_MULDIV, EX_MULT, 32'hFFFF_FFFD, 32'd5, 32'd0, MEM_OP_NOP, 5'd0, 1'b0, st);
        chk("mult_stalls", st, 0);
        run_op(ALU_MOVE, EX_MFLO, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd8, 1'b1, st);
        chk("mult_lo", mem_result, 32'hFFFF_FFF1);
        run_op(ALU_MOVE, EX_MFHI, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd9, 1'b1, st);
        chk("mult_hi", mem_result, 32'hFFFF_FFFF);

        run_op(ALU_MULDIV, EX_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, MEM_OP_NOP, 5'd0, 1'b0, st);
        chk("div_stalls", st, 32);
        run_op(ALU_MOVE, EX_MFLO, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd8, 1'b1, st);
        chk("div_lo", mem_result, 32'hFFFF_FFFD);
        run_op(ALU_MOVE, EX_MFHI, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd9, 1'b1, st);
        chk("div_hi", mem_result, 32'hFFFF_FFFF);
        run_op(ALU_MULDIV, EX_DIVU, 32'd7, 32'd0, 32'd0, MEM_OP_NOP, 5'd0, 1'b0, st);
        chk("div0_stalls", st, 0);
        run_op(ALU_MOVE, EX_MFLO, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd8, 1'b1, st);
        chk("div0_lo_kept", mem_result, 32'hFFFF_FFFD);

        run_op(ALU_MEM, 5'd0, 32'h0000_1000, 32'hCAFE_F00D, 32'hFFFF_FFFC, MEM_OP_SW, 5'd5, 1'b0, st);
        chk("mem_addr", mem_result, 32'h0000_0FFC);
        chk("mem_memop_pass", mem_memop, MEM_OP_SW);
        chk("mem_dest_pass", mem_dest, 5'd5);
        chk("mem_store", mem_storeData, 32'hCAFE_F00D);

        // Abort a divide part-way through with reset.
        drive(ALU_MULDIV, EX_DIV, 32'd100, 32'd3, 32'd0, MEM_OP_NOP, 5'd0, 1'b0);
        for (int c = 0; c < 11; c++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_stall", stall_req, 1'b1);
        rst = 1'b1;
        drive(ALU_NOP, 5'd0, 32'd0, 32'd0, 32'd0, MEM_OP_NOP, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        expect_bubble();
        chk("abort_stall", stall_req, 1'b0);
        check_outputs();

        for (int i = 0; i < 300; i++) begin
            sel = 3'($urandom_range(0, 7));
            case (sel)
                ALU_LOGIC:  op = 5'($urandom_range(0, 4));
                ALU_SHIFT:  op = 5'($urandom_range(5, 7));
                ALU_ARITH:  op = 5'($urandom_range(8, 13));
                ALU_MOVE:   op = 5'($urandom_range(14, 17));
                ALU_MULDIV: op = 5'($urandom_range(18, 21));
                default:    op = 5'($urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
            run_op(sel, op, pick(), pick(), pick(), 4'($urandom_range(0, 8)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), st);
        end
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
